// File: rtl/accel_sample_ctrl.sv
// Sequencer/supervisor for the accelerometer SPI interface: reset control, round capture,
// block averaging with valid/ack handshake, and a watchdog that restarts a stalled interface.
module accel_sample_ctrl #(
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = 4096,
    parameter int RST_HOLD = 8
) (
    input  logic        clk_SPI,
    input  logic        reset,
    input  logic        enable,
    input  logic        round_done,
    input  logic [11:0] x_in,
    input  logic [11:0] y_in,
    input  logic [11:0] z_in,
    output logic        spi_reset_n,
    output logic [11:0] x_avg,
    output logic [11:0] y_avg,
    output logic [11:0] z_avg,
    output logic        data_valid,
    input  logic        data_ack,
    output logic        overrun,
    output logic [7:0]  restarts,
    output logic [1:0]  ctrl_state
);

    localparam int AW = 12 + AVG_LOG2;
    localparam int NS = 1 << AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam int WW = $clog2(TIMEOUT) + 1;
    localparam int HW = $clog2(RST_HOLD) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [HW-1:0]        r_hold_cnt;
    logic [WW-1:0]        r_wd;
    logic [CW-1:0]        r_cnt;
    logic                 r_armed;
    logic                 r_rd_prev;
    logic                 r_spi_rst_n;
    logic                 r_valid;
    logic                 r_overrun;
    logic [7:0]           r_restarts;
    logic signed [AW-1:0] r_acc [3];
    logic [11:0]          r_avg [3];
    logic [11:0]          w_in  [3];

    logic w_capture;
    logic w_timeout;
    logic w_hold_entry;
    logic w_block_done;

    assign w_in[0] = x_in;
    assign w_in[1] = y_in;
    assign w_in[2] = z_in;

    // The first high level after the interface leaves reset carries no data, so a
    // capture needs a low level seen in RUN (armed) followed by a rising edge.
    assign w_capture    = (r_state == S_RUN) && round_done && !r_rd_prev && r_armed;
    assign w_block_done = (r_cnt == CW'(NS));
    assign w_hold_entry = (w_next == S_HOLD) && (r_state != S_HOLD);

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: if (enable) w_next = S_HOLD;
            S_HOLD: if (r_hold_cnt == HW'(RST_HOLD - 1)) w_next = S_RUN;
            S_RUN: begin
                if ((r_wd == WW'(TIMEOUT - 1)) && !w_capture) begin
                    w_next    = S_HOLD;
                    w_timeout = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (!enable) begin
            w_next    = S_IDLE;
            w_timeout = 1'b0;
        end
    end

    always_ff @(posedge clk_SPI or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_hold_cnt  <= '0;
            r_wd        <= '0;
            r_armed     <= 1'b0;
            r_rd_prev   <= 1'b0;
            r_spi_rst_n <= 1'b0;
            r_restarts  <= '0;
        end else begin
            r_state     <= w_next;
            r_rd_prev   <= round_done;
            r_spi_rst_n <= (w_next == S_RUN);

            if (w_hold_entry)              r_hold_cnt <= '0;
            else if (r_state == S_HOLD)    r_hold_cnt <= r_hold_cnt + HW'(1);

            if (w_hold_entry || w_capture) r_wd <= '0;
            else if (r_state == S_RUN)     r_wd <= r_wd + WW'(1);

            if (w_hold_entry)                        r_armed <= 1'b0;
            else if ((r_state == S_RUN) && !round_done) r_armed <= 1'b1;

            if (w_timeout && (r_restarts != 8'hFF)) r_restarts <= r_restarts + 8'd1;
        end
    end

    always_ff @(posedge clk_SPI or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            for (int i = 0; i < 3; i++) begin
                r_acc[i] <= '0;
                r_avg[i] <= '0;
            end
        end else begin
            if (w_hold_entry || w_block_done) begin
                r_cnt <= '0;
                for (int i = 0; i < 3; i++) r_acc[i] <= '0;
            end else if (w_capture) begin
                r_cnt <= r_cnt + CW'(1);
                for (int i = 0; i < 3; i++) r_acc[i] <= r_acc[i] + AW'($signed(w_in[i]));
            end
            // Arithmetic shift gives floor division for negative sums.
            if (w_block_done) begin
                for (int i = 0; i < 3; i++) r_avg[i] <= 12'(r_acc[i] >>> AVG_LOG2);
            end
        end
    end

    always_ff @(posedge clk_SPI or negedge reset) begin
        if (!reset) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_block_done)  r_valid <= 1'b1;
            else if (data_ack) r_valid <= 1'b0;

            if (w_block_done && r_valid && !data_ack) r_overrun <= 1'b1;
            else if (data_ack)                        r_overrun <= 1'b0;
        end
    end

    assign spi_reset_n = r_spi_rst_n;
    assign x_avg       = r_avg[0];
    assign y_avg       = r_avg[1];
    assign z_avg       = r_avg[2];
    assign data_valid  = r_valid;
    assign overrun     = r_overrun;
    assign restarts    = r_restarts;
    assign ctrl_state  = r_state;

endmodule

// File: doc/accel_sample_ctrl.md
# accel_sample_ctrl

Controller that sequences and supervises the accelerometer SPI interface on the `clk_SPI` domain. It drives the interface's active-low reset, detects each completed x/y/z round, block-averages 2^AVG_LOG2 rounds into stable 12-bit outputs with a valid/ack handshake, and restarts the interface through a watchdog if rounds stop arriving. It sits between the SPI interface and the MIPS-side register sync logic.

## Interface
- `AVG_LOG2`, 2: log2 of the number of rounds averaged per output (0..4).
- `TIMEOUT`, 4096: watchdog limit in cycles without a capture while in RUN.
- `RST_HOLD`, 8: cycles `spi_reset_n` is held low per restart (≥2).

- `clk_SPI`  in  1  clock (also clocks the SPI interface).
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  1 = run acquisition; 0 = hold the SPI interface in reset.
- `round_done`  in  1  delayed round-done flag from the SPI interface (1 = x/y/z triple coherent).
- `x_in`, `y_in`, `z_in`  in  12 each  raw two's-complement axis values from the SPI interface.
- `spi_reset_n`  out  1  active-low reset to the SPI interface.
- `x_avg`, `y_avg`, `z_avg`  out  12 each  averaged two's-complement axis values.
- `data_valid`  out  1  new average available.
- `data_ack`  in  1  consumer acknowledge; clears `data_valid`.
- `overrun`  out  1  sticky: an average was overwritten while unacknowledged.
- `restarts`  out  8  saturating count of watchdog restarts.
- `ctrl_state`  out  2  current state: IDLE=0, HOLD=1, RUN=2.

## Operation
- Reset values: `spi_reset_n`=0, all `*_avg`=0, `data_valid`=0, `overrun`=0, `restarts`=0, `ctrl_state`=IDLE; accumulators, sample count, watchdog and `armed` cleared.
- IDLE: `spi_reset_n`=0. `enable`=1 → HOLD.
- HOLD: `spi_reset_n`=0 for exactly RST_HOLD cycles, then → RUN. On entry: accumulators, sample count and watchdog cleared, `armed`=0.
- RUN: `spi_reset_n`=1. `armed` sets once `round_done`=0 is sampled (the first post-reset high level carries no data).
- Capture: at a posedge where `round_done`=1, registered previous `round_done`=0, and `armed`=1, sample `x_in/y_in/z_in` into signed accumulators of width 12+AVG_LOG2 (sign-extended add) and increment the sample count.
- When the count reaches 2^AVG_LOG2: each `*_avg` = accumulator arithmetic-shifted right by AVG_LOG2 (truncation toward −∞); `data_valid`=1; accumulators and count cleared (block average, no overlap).
- Handshake: `data_ack`=1 with `data_valid`=1 clears `data_valid`. A simultaneous new average wins: `data_valid` stays 1, no overrun. A new average while `data_valid`=1 without ack sets `overrun`. `overrun` is cleared by `data_ack`, except when it is set in the same cycle, in which case set wins.
- Watchdog: counts cycles in RUN; cleared on each capture. At TIMEOUT−1 without a capture in that cycle → HOLD and `restarts` += 1 (saturating at 255). A capture in the same cycle wins; no restart.
- `enable`=0 in any state → IDLE next cycle. The partial block is discarded. `*_avg`, `data_valid`, `overrun` and `restarts` are retained.
- `data_ack` is honoured in every state.

## Timing
- The capture edge is detected and the accumulator is written at posedge E.
- For the final sample of a block, `*_avg` and `data_valid` are visible after posedge E+1 (1-cycle latency).
- Startup: `enable` rises → HOLD next posedge → RUN after RST_HOLD further cycles.
- `ctrl_state` reflects the registered state; all outputs are registered.

## Test plan
- Reset, then `enable`=1 → `spi_reset_n` low for exactly 8 cycles, then high; `ctrl_state` goes 0→1→2.
- AVG_LOG2=2; four rounds with x=100, 101, 102, 103 and y=−4, −4, −4, −5 (0xFFB) → `x_avg`=101, `y_avg`=−5 (0xFFB), `data_valid`=1 one cycle after the 4th edge. An initial `round_done`=1 level before any low is ignored.
- `data_valid` held without ack and a second block completes → `overrun`=1 and `*_avg` updated. Ack → `data_valid`=0 and `overrun`=0. Ack coincident with a new block → `data_valid`=1, `overrun`=0.
- TIMEOUT=64 with `round_done` stuck at 1 → HOLD entered at cycle 64 of RUN and `restarts`=1. Repeated 300 times → `restarts` saturates at 255.
- `enable` dropped after 2 of 4 samples → IDLE with `spi_reset_n`=0 and previous averages held. Re-enable plus 4 rounds → average uses only the new samples.
- Async `reset` asserted mid-RUN between clock edges → all outputs take their reset values immediately.
